// File: rtl/iq_energy_sched.sv
// iq_energy_sched: round-robin scheduler sharing one I/Q square-and-accumulate datapath between two channels.
// Define ENERGY_DETECT_EN to add the threshold input and registered detect output.
module iq_energy_sched #(
    parameter int WIN_LEN = 16,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ch0_valid,
    input  logic [7:0]  ch0_real,
    input  logic [7:0]  ch0_imag,
    output logic        ch0_ready,
    input  logic        ch1_valid,
    input  logic [7:0]  ch1_real,
    input  logic [7:0]  ch1_imag,
    output logic        ch1_ready,
    output logic [29:0] energy,
    output logic        energy_ch,
    output logic        energy_valid,
`ifdef ENERGY_DETECT_EN
    input  logic [29:0] threshold,
    output logic        detect,
`endif
    output logic        busy
);
    typedef enum logic {IDLE, ACCUM} state_t;

    state_t             state_q, state_d;
    logic               grant_q, grant_d;
    logic               last_ch_q, last_ch_d;
    logic [29:0]        acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [29:0]        energy_q, energy_d;
    logic               energy_ch_q, energy_ch_d;
    logic               energy_valid_q, energy_valid_d;

    logic [7:0]         sel_re, sel_im;
    logic signed [17:0] r_s, q_s;
    logic [17:0]        e;
    logic [29:0]        acc_sum;
    logic               accept, last;

    // Offset-binary to odd symmetric value: 2*x - 255 spans -255..+255.
    assign sel_re  = grant_q ? ch1_real : ch0_real;
    assign sel_im  = grant_q ? ch1_imag : ch0_imag;
    assign r_s     = $signed({9'b0, sel_re, 1'b0}) - 18'sd255;
    assign q_s     = $signed({9'b0, sel_im, 1'b0}) - 18'sd255;
    assign e       = r_s * r_s + q_s * q_s;
    assign acc_sum = acc_q + {12'b0, e};
    assign accept  = (state_q == ACCUM) && (grant_q ? ch1_valid : ch0_valid);
    assign last    = accept && (cnt_q == CNT_W'(WIN_LEN - 1));

    // Ready comes only from registered state, never from the valids.
    assign ch0_ready    = (state_q == ACCUM) && !grant_q;
    assign ch1_ready    = (state_q == ACCUM) && grant_q;
    assign busy         = (state_q == ACCUM);
    assign energy       = energy_q;
    assign energy_ch    = energy_ch_q;
    assign energy_valid = energy_valid_q;

`ifdef ENERGY_DETECT_EN
    logic detect_q, detect_d;
    assign detect = detect_q;
    always_comb detect_d = last ? (acc_sum >= threshold) : detect_q;
    always_ff @(posedge clk)
        detect_q <= rst ? 1'b0 : detect_d;
`endif

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        last_ch_d      = last_ch_q;
        acc_d          = acc_q;
        cnt_d          = cnt_q;
        energy_d       = energy_q;
        energy_ch_d    = energy_ch_q;
        energy_valid_d = 1'b0;
        if (state_q == IDLE) begin
            if (ch0_valid || ch1_valid) begin
                state_d = ACCUM;
                grant_d = (ch0_valid && ch1_valid) ? !last_ch_q : ch1_valid;
                acc_d   = '0;
                cnt_d   = '0;
            end
        end else if (accept) begin
            acc_d = acc_sum;
            cnt_d = cnt_q + 1'b1;
            if (last) begin
                state_d        = IDLE;
                energy_d       = acc_sum;
                energy_ch_d    = grant_q;
                energy_valid_d = 1'b1;
                last_ch_d      = grant_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            grant_q        <= 1'b0;
            last_ch_q      <= 1'b1;
            acc_q          <= '0;
            cnt_q          <= '0;
            energy_q       <= '0;
            energy_ch_q    <= 1'b0;
            energy_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            last_ch_q      <= last_ch_d;
            acc_q          <= acc_d;
            cnt_q          <= cnt_d;
            energy_q       <= energy_d;
            energy_ch_q    <= energy_ch_d;
            energy_valid_q <= energy_valid_d;
        end
    end
endmodule

// File: tb/tb_iq_energy_sched.sv
// tb_iq_energy_sched: directed and random stimulus against a window-level energy model.
module tb_iq_energy_sched;
    localparam int WL = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ch0_valid, ch1_valid;
    logic [7:0]  ch0_real, ch0_imag, ch1_real, ch1_imag;
    logic        ch0_ready, ch1_ready;
    logic [29:0] energy;
    logic        energy_ch, energy_valid, busy;
`ifdef ENERGY_DETECT_EN
    logic [29:0] threshold = 30'd0;
    logic        detect;
`endif

    iq_energy_sched #(.WIN_LEN(WL), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .ch0_valid(ch0_valid), .ch0_real(ch0_real), .ch0_imag(ch0_imag), .ch0_ready(ch0_ready),
        .ch1_valid(ch1_valid), .ch1_real(ch1_real), .ch1_imag(ch1_imag), .ch1_ready(ch1_ready),
        .energy(energy), .energy_ch(energy_ch), .energy_valid(energy_valid),
`ifdef ENERGY_DETECT_EN
        .threshold(threshold), .detect(detect),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Model: a window is "open" on one channel and collects sample energies.
    bit     m_open, m_ch, m_last, m_ev, m_ech, m_det;
    int     m_n;
    longint m_sum, m_energy;

    function automatic longint samp_e(input int re, input int im);
        int r = 2 * re - 255;
        int q = 2 * im - 255;
        return longint'(r * r + q * q);
    endfunction

    task automatic model_reset();
        m_open = 0; m_ch = 0; m_last = 1; m_ev = 0; m_ech = 0; m_det = 0;
        m_n = 0; m_sum = 0; m_energy = 0;
    endtask

    // Each call: compare outputs at the falling edge, drive the next inputs, advance the model.
    task automatic cyc(input bit r, input bit v0, input int a0, input int b0,
                       input bit v1, input int a1, input int b1);
        @(negedge clk);
        chk("ready0", ch0_ready, m_open && !m_ch);
        chk("ready1", ch1_ready, m_open && m_ch);
        chk("busy", busy, m_open);
        chk("ev", energy_valid, m_ev);
        chk("energy", energy, m_energy);
        chk("ech", energy_ch, m_ech);
`ifdef ENERGY_DETECT_EN
        chk("detect", detect, m_det);
`endif
        rst = r; ch0_valid = v0; ch0_real = 8'(a0); ch0_imag = 8'(b0);
        ch1_valid = v1; ch1_real = 8'(a1); ch1_imag = 8'(b1);
        if (r) begin
            model_reset();
        end else begin
            m_ev = 0;
            if (!m_open) begin
                if (v0 || v1) begin
                    m_open = 1;
                    m_ch = (v0 && v1) ? !m_last : v1;
                    m_n = 0; m_sum = 0;
                end
            end else if (m_ch ? v1 : v0) begin
                m_sum += m_ch ? samp_e(a1, b1) : samp_e(a0, b0);
                m_n++;
                if (m_n == WL) begin
                    m_energy = m_sum; m_ech = m_ch; m_ev = 1; m_last = m_ch; m_open = 0;
`ifdef ENERGY_DETECT_EN
                    m_det = m_sum >= longint'(threshold);
`endif
                end
            end
        end
    endtask

    initial begin
        rst = 1; ch0_valid = 1; ch1_valid = 1;
        ch0_real = 0; ch0_imag = 0; ch1_real = 0; ch1_imag = 0;
        model_reset();
        @(posedge clk);
        // Reset held with both valids high, then first contention goes to ch0.
        repeat (2) cyc(1, 1, 0, 0, 1, 0, 0);
        cyc(0, 1, 10, 20, 1, 30, 40);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("first_grant_ch0", ch0_ready, 1);
        repeat (4) cyc(0, 1, 255, 255, 0, 0, 0);
        repeat (2) cyc(0, 0, 0, 0, 0, 0, 0);
        // Full-scale window on ch0.
        repeat (5) cyc(0, 1, 255, 255, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("full_scale", energy, 520200);
        chk("full_scale_ev", energy_valid, 1);
        chk("full_scale_ch", energy_ch, 0);
        repeat (5) cyc(0, 1, 127, 128, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("near_mid", energy, 8);
        // Continuous contention alternates channels.
        for (int w = 0; w < 20; w++) cyc(0, 1, w, 3 * w, 1, 200 - w, w + 7);
        // Toggling valid on ch0 with all-zero data.
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++) cyc(0, k[0] == 1'b0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("toggle_zero", energy, 520200);
        // Reset mid-window discards the partial sum.
        repeat (3) cyc(0, 1, 255, 0, 0, 0, 0);
        cyc(1, 1, 255, 0, 0, 0, 0);
        repeat (5) cyc(0, 1, 128, 128, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("post_rst", energy, 8);
`ifdef ENERGY_DETECT_EN
        threshold = 30'd520200;
        repeat (5) cyc(0, 1, 255, 255, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("detect_eq", detect, 1);
        threshold = 30'd520201;
        repeat (5) cyc(0, 1, 255, 255, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("detect_above", detect, 0);
`endif
        // Random traffic with occasional resets.
        for (int k = 0; k < 600; k++) begin
`ifdef ENERGY_DETECT_EN
            if (k % 50 == 0) threshold = 30'($urandom_range(0, 520200));
`endif
            cyc($urandom_range(0, 79) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 255),
                $urandom_range(0, 255), $urandom_range(0, 9) < 6, $urandom_range(0, 255),
                $urandom_range(0, 255));
        end
        cyc(0, 0, 0, 0, 0, 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/iq_energy_sched.md
# iq_energy_sched

Windowed I/Q energy scheduler that time-shares one square-and-accumulate datapath between two 8-bit offset-binary I/Q channels. Grants the datapath to one channel per window, accepts WIN_LEN samples from it over a valid/ready handshake, and accumulates (2·I−255)² + (2·Q−255)² per sample. Emits a 30-bit window energy with channel tag and one-cycle valid strobe. Sits between the sample front-end and the downstream detection/decision logic.

## Interface
- WIN_LEN, 16, samples per window; 2..(2^CNT_W − 1)
- CNT_W, 8, sample counter width; must be ≤ 13 so a full window cannot overflow 30 bits
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- ch0_valid  in  1  channel 0 sample present
- ch0_real, ch0_imag  in  8 each  channel 0 offset-binary I/Q
- ch0_ready  out  1  channel 0 sample accepted this cycle when ch0_valid high
- ch1_valid, ch1_real, ch1_imag, ch1_ready  same as channel 0
- energy  out  30  last completed window energy, unsigned
- energy_ch  out  1  channel that produced `energy`
- energy_valid  out  1  one-cycle pulse, `energy`/`energy_ch` updated
- busy  out  1  high while a window is in progress
- threshold  in  30  detection threshold (only with ENERGY_DETECT_EN)
- detect  out  1  window energy ≥ threshold (only with ENERGY_DETECT_EN)

## Operation
- Per-sample term: r = 2·real − 255, q = 2·imag − 255, signed 9-bit, range −255..+255 (odd only); e = r² + q², 0..130050, 18-bit unsigned.
- Accumulator 30-bit unsigned; no saturation needed given the CNT_W bound.
- FSM states: IDLE, ACCUM.
  - IDLE: both ready low, busy low. If any chN_valid high, register grant and go to ACCUM next cycle; clear acc and cnt.
  - Arbitration: only one valid → that channel. Both valid → channel ≠ last_ch (round-robin). Neither → stay IDLE.
  - ACCUM: chN_ready = (grant == N), driven from registered state only; no combinational path from valid to ready. Non-granted ready held low. Each cycle with granted valid & ready: acc += e, cnt += 1. Cycles with valid low: no change.
  - Last sample (cnt == WIN_LEN−1 and accept): energy ← acc + e, energy_ch ← grant, energy_valid ← 1, last_ch ← grant, next state IDLE.
- Window is locked to its granted channel; the other channel's valid is ignored until the window ends. No abort other than rst.
- energy and energy_ch hold their value until the next completed window.

## Timing
- Reset values: state IDLE, ch0_ready/ch1_ready 0, busy 0, energy 0, energy_ch 0, energy_valid 0, detect 0, acc 0, cnt 0, last_ch 1 (so ch0 wins the first contention).
- Grant latency: valid seen in IDLE at cycle t → ready high at t+1.
- Throughput: one sample per cycle in ACCUM; WIN_LEN+1 cycles per window minimum (one IDLE gap between windows).
- energy_valid asserted the cycle after the last accept edge, for exactly one cycle; ready deasserts in that same cycle.
- rst mid-window: synchronous return to IDLE with reset values; partial window discarded; no energy_valid.
- rst has priority over every other event in the same cycle.

## Configuration
- ENERGY_DETECT_EN defined: threshold input and detect output present; detect registered with energy_valid, detect ← (acc + e) ≥ threshold on last-sample edge, held with energy; reset 0.
- Not defined: threshold and detect ports absent; no comparator logic.

## Test plan
- Reset: hold rst 3 cycles with both valids high → all outputs 0, both ready 0; release → ch0 granted first (ch0_ready high one cycle later).
- WIN_LEN=4, ch0 only, real=imag=255 every cycle → 4 accepts, energy=520200, energy_ch=0, energy_valid one cycle after 4th accept; real=127, imag=128 window → energy=8.
- Both channels continuously valid, WIN_LEN=4, distinct data → windows granted ch0, ch1, ch0, ch1; one IDLE cycle between; energy_ch alternates; non-granted ready never high.
- ch0 valid toggling every other cycle, real=imag=0 → only accepted samples counted; energy=520200 after 4 accepts (8 cycles).
- rst asserted after 2 accepts → no energy_valid; next window with real=imag=128 (e=2) yields energy=8, not contaminated.
- ENERGY_DETECT_EN, threshold=520200: all-255 window → detect=1; threshold=520201 → detect=0.
